// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port Memory model between the instruction-fetch unit (IF)
// and the load/store unit (LS). One transaction is in flight at a time:
//   IDLE   -> accept one request (handshake), latch its fields
//   ACCESS -> drive Memory for MEM_LAT cycles, then capture read data
//   RESP   -> one-cycle resp_valid pulse to the owner, back to IDLE
//
// Parameters:
//   MEM_LAT  cycles from mem_ren/mem_wen assertion to data valid / write done
//            (must be >= 1)
//
// Optional feature (compile-time macro):
//   MEM_ARB_RR_EN  round-robin between IF and LS on contention; when
//                  undefined, LS has fixed priority over IF.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req_valid/ready, if_addr     IF word-read request channel
//   if_resp_valid, if_rdata         IF response pulse and fetched word
//   ls_req_valid/ready, ls_wen, ls_addr, ls_wdata,
//   ls_suffix_b/h, ls_sext          LS request channel
//   ls_resp_valid, ls_rdata         LS response pulse, load data (0 on store)
//   mem_*                           Memory pins (ren/raddr/wen/waddr/wdata/
//                                   suffix_b/suffix_h/sext out, rdata in)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_wen,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic        ls_suffix_b,
  input  logic        ls_suffix_h,
  input  logic        ls_sext,
  output logic        ls_resp_valid,
  output logic [31:0] ls_rdata,
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_suffix_b,
  output logic        mem_suffix_h,
  output logic        mem_sext,
  input  logic [31:0] mem_rdata
);

  if (MEM_LAT == 0) begin : g_bad_mem_lat
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  localparam int unsigned   CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic       {OWN_IF, OWN_LS}            owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q, wdata_q;
  logic          wen_q, sfx_b_q, sfx_h_q, sext_q;
  logic [31:0]   if_rdata_q, ls_rdata_q;
  logic          grant_ls, hs_if, hs_ls, access_done;

  // ---------------------------------------------------------------------------
  // Arbitration: grant_ls says LS would win if the arbiter is idle.
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
  owner_t last_grant_q;

  // On contention the requester that was not granted last time wins.
  assign grant_ls = ls_req_valid & (~if_req_valid | (last_grant_q == OWN_IF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant_q <= OWN_IF;
    else if (hs_ls) last_grant_q <= OWN_LS;
    else if (hs_if) last_grant_q <= OWN_IF;
  end
`else
  assign grant_ls = ls_req_valid;
`endif

  assign ls_req_ready = (state_q == S_IDLE) & grant_ls;
  assign if_req_ready = (state_q == S_IDLE) & if_req_valid & ~grant_ls;
  assign hs_ls        = ls_req_valid & ls_req_ready;
  assign hs_if        = if_req_valid & if_req_ready;
  assign access_done  = (state_q == S_ACCESS) && (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for state_d.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (hs_if || hs_ls) state_d = S_ACCESS;
      S_ACCESS: if (access_done)    state_d = S_RESP;
      S_RESP:                       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: Memory pins only live in ACCESS, so an async reset drops
  // mem_ren/mem_wen immediately through state_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_ren       = 1'b0;
    mem_wen       = 1'b0;
    mem_raddr     = '0;
    mem_waddr     = '0;
    mem_wdata     = '0;
    mem_suffix_b  = 1'b0;
    mem_suffix_h  = 1'b0;
    mem_sext      = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    unique case (state_q)
      S_ACCESS: begin
        mem_ren      = ~wen_q;
        mem_wen      = wen_q;
        mem_raddr    = addr_q;
        mem_waddr    = addr_q;
        mem_wdata    = wdata_q;
        mem_suffix_b = sfx_b_q;
        mem_suffix_h = sfx_h_q;
        mem_sext     = sext_q;
      end
      S_RESP: begin
        if_resp_valid = (owner_q == OWN_IF);
        ls_resp_valid = (owner_q == OWN_LS);
      end
      default: ;
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;

  // ---------------------------------------------------------------------------
  // Request latch, latency counter and response data capture
  // ---------------------------------------------------------------------------
  // NOTE: these are a handful of flops, not a RAM, so they take the async
  // reset and the rdata outputs read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      sfx_b_q    <= 1'b0;
      sfx_h_q    <= 1'b0;
      sext_q     <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (hs_ls) begin
        owner_q <= OWN_LS;
        addr_q  <= ls_addr;
        wdata_q <= ls_wdata;
        wen_q   <= ls_wen;
        sfx_b_q <= ls_suffix_b;
        sfx_h_q <= ls_suffix_h;
        sext_q  <= ls_sext;
        cnt_q   <= CNT_INIT;
      end else if (hs_if) begin
        // Fetches are always plain 4-byte reads.
        owner_q <= OWN_IF;
        addr_q  <= if_addr;
        wdata_q <= '0;
        wen_q   <= 1'b0;
        sfx_b_q <= 1'b0;
        sfx_h_q <= 1'b0;
        sext_q  <= 1'b0;
        cnt_q   <= CNT_INIT;
      end else if (state_q == S_ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end

      if (access_done) begin
        if (owner_q == OWN_LS) ls_rdata_q <= wen_q ? 32'h0 : mem_rdata;
        else                   if_rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. u_dut runs with MEM_LAT=1, u_dut3 with
// MEM_LAT=3. Stimulus pushes expected response data (and expected owner
// order) into queues; a monitor on the falling edge pops and compares
// whenever a resp_valid pulse appears. Directed timing checks sit inline.
// Define MEM_ARB_RR_EN for both bench and RTL to check round-robin grants.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // MEM_LAT = 1 instance
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_suffix_b, ls_suffix_h, ls_sext;
  logic        ls_resp_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

  // MEM_LAT = 3 instance
  logic        if_req_valid3, if_req_ready3, if_resp_valid3;
  logic [31:0] if_addr3, if_rdata3;
  logic        ls_req_valid3, ls_req_ready3, ls_wen3, ls_suffix_b3, ls_suffix_h3, ls_sext3;
  logic        ls_resp_valid3;
  logic [31:0] ls_addr3, ls_wdata3, ls_rdata3;
  logic        mem_ren3, mem_wen3, mem_suffix_b3, mem_suffix_h3, mem_sext3;
  logic [31:0] mem_raddr3, mem_waddr3, mem_wdata3, mem_rdata3;

  mem_arbiter #(.MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_wen(ls_wen),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_suffix_b(ls_suffix_b),
    .ls_suffix_h(ls_suffix_h), .ls_sext(ls_sext),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_suffix_b(mem_suffix_b),
    .mem_suffix_h(mem_suffix_h), .mem_sext(mem_sext), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid3), .if_req_ready(if_req_ready3), .if_addr(if_addr3),
    .if_resp_valid(if_resp_valid3), .if_rdata(if_rdata3),
    .ls_req_valid(ls_req_valid3), .ls_req_ready(ls_req_ready3), .ls_wen(ls_wen3),
    .ls_addr(ls_addr3), .ls_wdata(ls_wdata3), .ls_suffix_b(ls_suffix_b3),
    .ls_suffix_h(ls_suffix_h3), .ls_sext(ls_sext3),
    .ls_resp_valid(ls_resp_valid3), .ls_rdata(ls_rdata3),
    .mem_ren(mem_ren3), .mem_raddr(mem_raddr3), .mem_wen(mem_wen3),
    .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3), .mem_suffix_b(mem_suffix_b3),
    .mem_suffix_h(mem_suffix_h3), .mem_sext(mem_sext3), .mem_rdata(mem_rdata3)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];
  logic [31:0] ls3_q[$];
  bit          ord_q[$];   // expected response owner order: 0 = IF, 1 = LS

`ifdef MEM_ARB_RR_EN
  bit exp_ls[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
  bit exp_ls[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Response monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (if_resp_valid || ls_resp_valid) begin
      check("resp_exclusive", 32'(if_resp_valid & ls_resp_valid), 0);
      if (ord_q.size() == 0) check("resp_unexpected", 32'(if_resp_valid | ls_resp_valid), 0);
      else                   check("resp_owner", 32'(ls_resp_valid), 32'(ord_q.pop_front()));
    end
    if (if_resp_valid) begin
      if (if_q.size() == 0) check("if_resp_unexpected", 32'(if_resp_valid), 0);
      else                  check("if_rdata", if_rdata, if_q.pop_front());
    end
    if (ls_resp_valid) begin
      if (ls_q.size() == 0) check("ls_resp_unexpected", 32'(ls_resp_valid), 0);
      else                  check("ls_rdata", ls_rdata, ls_q.pop_front());
    end
    if (ls_resp_valid3) begin
      if (ls3_q.size() == 0) check("ls3_resp_unexpected", 32'(ls_resp_valid3), 0);
      else                   check("ls3_rdata", ls_rdata3, ls3_q.pop_front());
    end
    if (if_resp_valid3) check("if3_resp_unexpected", 32'(if_resp_valid3), 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] data;
    int          waited;

    if_req_valid = 0; if_addr = 0;
    ls_req_valid = 0; ls_wen = 0; ls_addr = 0; ls_wdata = 0;
    ls_suffix_b = 0; ls_suffix_h = 0; ls_sext = 0; mem_rdata = 0;
    if_req_valid3 = 0; if_addr3 = 0;
    ls_req_valid3 = 0; ls_wen3 = 0; ls_addr3 = 0; ls_wdata3 = 0;
    ls_suffix_b3 = 0; ls_suffix_h3 = 0; ls_sext3 = 0; mem_rdata3 = 0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    sample();
    check("reset_ctrl", {mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext,
                         if_resp_valid, ls_resp_valid, if_req_ready, ls_req_ready}, 0);
    check("reset_raddr", mem_raddr, 0);
    check("reset_waddr", mem_waddr, 0);
    check("reset_wdata", mem_wdata, 0);
    check("reset_if_rdata", if_rdata, 0);
    check("reset_ls_rdata", ls_rdata, 0);
    rst_n = 1'b1;

    // ---- IF read, MEM_LAT=1 ----
    next_cycle();                              // cycle T
    if_req_valid = 1; if_addr = 32'h8000_0000; mem_rdata = 32'h0000_0297;
    if_q.push_back(32'h0000_0297); ord_q.push_back(1'b0);
    sample();
    check("if_rd_ready", 32'(if_req_ready), 1);
    check("if_rd_ls_ready", 32'(ls_req_ready), 0);
    next_cycle();                              // T+1: ACCESS
    if_req_valid = 0;
    sample();
    check("if_rd_mem_ren", 32'(mem_ren), 1);
    check("if_rd_mem_wen", 32'(mem_wen), 0);
    check("if_rd_raddr", mem_raddr, 32'h8000_0000);
    check("if_rd_early_resp", 32'(if_resp_valid), 0);
    next_cycle();                              // T+2: RESP
    sample();
    check("if_rd_resp", 32'(if_resp_valid), 1);
    check("if_rd_resp_mem_ren", 32'(mem_ren), 0);
    next_cycle();                              // T+3: IDLE
    sample();
    check("if_rd_pulse_end", 32'(if_resp_valid), 0);
    check("if_rd_hold", if_rdata, 32'h0000_0297);

    // ---- LS byte store ----
    next_cycle();
    ls_req_valid = 1; ls_wen = 1; ls_addr = 32'h8000_0100; ls_wdata = 32'hDEAD_BEEF;
    ls_suffix_b = 1; mem_rdata = 32'h1234_5678;
    ls_q.push_back(32'h0); ord_q.push_back(1'b1);
    sample();
    check("st_ready", 32'(ls_req_ready), 1);
    check("st_idle_mem_wen", 32'(mem_wen), 0);
    next_cycle();
    ls_req_valid = 0; ls_wen = 0; ls_suffix_b = 0; ls_wdata = 0;
    sample();
    check("st_mem_wen", 32'(mem_wen), 1);
    check("st_mem_ren", 32'(mem_ren), 0);
    check("st_waddr", mem_waddr, 32'h8000_0100);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_suffix_b", 32'(mem_suffix_b), 1);
    next_cycle();
    sample();
    check("st_resp", 32'(ls_resp_valid), 1);
    check("st_resp_mem_wen", 32'(mem_wen), 0);
    next_cycle();

    // ---- contention: IF and LS both valid, then LS drops ----
    if_req_valid = 1; if_addr = 32'h8000_0004;
    ls_req_valid = 1; ls_wen = 0; ls_addr = 32'h8000_0040;
    for (int r = 0; r < 5; r++) begin
      if (r == 4) ls_req_valid = 0;
      waited = 0;
      sample();
      while (!(if_req_ready || ls_req_ready) && waited < 8) begin
        next_cycle();
        sample();
        waited++;
      end
      check($sformatf("grant_seen_r%0d", r), 32'(if_req_ready | ls_req_ready), 1);
      check($sformatf("ready_onehot_r%0d", r), 32'(if_req_ready & ls_req_ready), 0);
      check($sformatf("grant_ls_r%0d", r), 32'(ls_req_ready), 32'(exp_ls[r]));
      data = 32'h1000_0000 + 32'(r);
      mem_rdata = data;
      if (ls_req_ready) begin ls_q.push_back(data); ord_q.push_back(1'b1); end
      else              begin if_q.push_back(data); ord_q.push_back(1'b0); end
      next_cycle();                            // handshake done
      if (r == 4) if_req_valid = 0;
    end
    repeat (3) next_cycle();

    // ---- MEM_LAT=3: sign-extending halfword load ----
    ls_req_valid3 = 1; ls_wen3 = 0; ls_addr3 = 32'h8000_0200;
    ls_sext3 = 1; ls_suffix_h3 = 1; mem_rdata3 = 0;
    ls3_q.push_back(32'hFFFF_8003);
    sample();
    check("lat3_ready", 32'(ls_req_ready3), 1);
    next_cycle();
    ls_req_valid3 = 0; ls_sext3 = 0; ls_suffix_h3 = 0;
    for (int k = 1; k <= 3; k++) begin
      mem_rdata3 = (k == 3) ? 32'hFFFF_8003 : (32'hAAAA_0000 + 32'(k));
      sample();
      check($sformatf("lat3_ren_c%0d", k), 32'(mem_ren3), 1);
      check($sformatf("lat3_fields_c%0d", k), {mem_suffix_h3, mem_sext3, mem_suffix_b3, mem_wen3}, 4'b1100);
      check($sformatf("lat3_raddr_c%0d", k), mem_raddr3, 32'h8000_0200);
      check($sformatf("lat3_early_resp_c%0d", k), 32'(ls_resp_valid3), 0);
      next_cycle();
    end
    mem_rdata3 = 32'h5555_5555;                // T+4
    sample();
    check("lat3_resp", 32'(ls_resp_valid3), 1);
    check("lat3_resp_ren", 32'(mem_ren3), 0);
    next_cycle();
    sample();
    check("lat3_pulse_end", 32'(ls_resp_valid3), 0);
    check("lat3_hold", ls_rdata3, 32'hFFFF_8003);

    // ---- reset during ACCESS of an IF read ----
    next_cycle();
    if_req_valid = 1; if_addr = 32'h8000_0008; mem_rdata = 32'hBAD0_BAD0;
    sample();
    check("rst_if_ready", 32'(if_req_ready), 1);
    next_cycle();
    if_req_valid = 0;
    sample();
    check("rst_pre_mem_ren", 32'(mem_ren), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_ren_drop", 32'(mem_ren), 0);
    check("rst_raddr_drop", mem_raddr, 0);
    next_cycle();
    #3 rst_n = 1'b1;
    next_cycle();                              // first IDLE cycle after reset
    ls_req_valid = 1; ls_wen = 0; ls_addr = 32'h8000_0300; mem_rdata = 32'h0BAD_F00D;
    ls_q.push_back(32'h0BAD_F00D); ord_q.push_back(1'b1);
    sample();
    check("post_rst_ls_ready", 32'(ls_req_ready), 1);
    check("post_rst_no_if_resp", 32'(if_resp_valid), 0);
    next_cycle();
    ls_req_valid = 0;
    next_cycle();
    sample();
    check("post_rst_ls_resp", 32'(ls_resp_valid), 1);
    repeat (2) next_cycle();

    check("if_q_drained", 32'(if_q.size()), 0);
    check("ls_q_drained", 32'(ls_q.size()), 0);
    check("ls3_q_drained", 32'(ls3_q.size()), 0);
    check("ord_q_drained", 32'(ord_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port `Memory` model between two requesters: the instruction-fetch unit (IF) and the load/store unit (LS).
- Sequences each transaction onto `Memory`'s ren/raddr/wen/waddr/wdata/suffix/sext pins and returns read data through a one-cycle response pulse.
- Sits between the IFU/LSU and the `Memory` instance in the npc core. Only one transaction is in flight at any time.

Parameters:
- MEM_LAT, 1: cycles from mem_ren/mem_wen assertion to mem_rdata being valid or the write being committed. Must be ≥1; 0 is illegal and is rejected at elaboration.

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  32  IF byte address; always a 4-byte read
- if_resp_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched word
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_wen  in  1  1 = store, 0 = load
- ls_addr  in  32  LS byte address
- ls_wdata  in  32  store data
- ls_suffix_b  in  1  byte access
- ls_suffix_h  in  1  halfword access
- ls_sext  in  1  sign-extend load
- ls_resp_valid  out  1  one-cycle pulse; load data valid, or store done
- ls_rdata  out  32  load data; 0 for stores
- mem_ren  out  1  to Memory.ren
- mem_raddr  out  32  to Memory.raddr
- mem_wen  out  1  to Memory.wen
- mem_waddr  out  32  to Memory.waddr
- mem_wdata  out  32  to Memory.wdata
- mem_suffix_b  out  1  to Memory.suffix_b
- mem_suffix_h  out  1  to Memory.suffix_h
- mem_sext  out  1  to Memory.sext
- mem_rdata  in  32  from Memory.rdata

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset: state=IDLE, counter=0, owner=IF, last_grant=IF. All mem_* outputs, both resp_valid outputs and both rdata outputs are 0.
- Ready signals:
  - Asserted only in IDLE. They are combinational from the valids and the state.
  - At most one ready is high per cycle.
  - Without the optional feature, LS has fixed priority: ls_req_ready=ls_req_valid; if_req_ready=if_req_valid & ~ls_req_valid.
- Handshake (IDLE, valid & ready):
  - Latch owner, addr, wdata, wen, suffix_b/h and sext. For IF, wen, suffixes and sext are forced to 0.
  - Set counter=MEM_LAT-1 and go to ACCESS.
  - Request fields are sampled only at the handshake. A valid dropped before the handshake is legal and has no effect.
- ACCESS:
  - mem_ren=~wen_l and mem_wen=wen_l, held for the whole state.
  - mem_raddr and mem_waddr both carry addr_l; mem_wdata, suffix and sext carry the latched values.
  - Counter decrements each cycle. When counter==0: capture mem_rdata for loads (0 for stores) into the owner's rdata register, then go to RESP.
- RESP:
  - All mem_* outputs are 0.
  - The owner's resp_valid=1 for exactly one cycle. Requesters must accept; there is no response back-pressure.
  - Next state is IDLE. rdata holds its value until the next capture.
- Latency: handshake at cycle T → resp_valid at cycle T+MEM_LAT+1. Throughput is one transaction per MEM_LAT+2 cycles.
- Simultaneous IF+LS valid in IDLE: one is granted per the priority rule; the loser stays pending with its valid held.
- suffix_b and suffix_h both high: suffix_b wins, matching Memory's decode. mem_* passes both through unchanged.
- Reset mid-transaction: asynchronous return to IDLE. mem_ren and mem_wen drop immediately. The pending response is discarded and no resp_valid is issued. A write already committed by Memory is not rolled back.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Round-robin between IF and LS when both are valid. The requester not equal to last_grant wins.
  - last_grant updates on every handshake and resets to IF, so LS wins the first contention.
  - When only one requester is valid, it is granted.
- MEM_ARB_RR_EN undefined: fixed LS priority and no last_grant register.

Test Plan:
- Reset, then IF read, addr 0x8000_0000, mem_rdata=0x0000_0297, MEM_LAT=1 → handshake cycle T; mem_ren=1 at T+1; if_resp_valid=1 with if_rdata=0x0000_0297 at T+2; idle at T+3.
- LS store, addr 0x8000_0100, wdata 0xDEADBEEF, suffix_b=1 → mem_wen=1 for 1 cycle with mem_suffix_b=1; ls_resp_valid pulses with ls_rdata=0; mem_ren stays 0.
- IF and LS valid in the same IDLE cycle, 4 back-to-back rounds:
  - Fixed priority: LS granted every time; IF waits until ls_req_valid drops.
  - MEM_ARB_RR_EN: grants are LS, IF, LS, IF.
- MEM_LAT=3, LS load with sext=1, suffix_h=1 → mem_ren held 3 cycles; ls_resp_valid at T+4; data equals mem_rdata sampled in the last ACCESS cycle.
- rst_n pulled low during ACCESS of an IF read → mem_ren=0 immediately; no if_resp_valid; after release, a new LS request is accepted in the first IDLE cycle.
